// File: rtl/dbus_uart_pkg.sv
// dbus_uart_pkg -- shared definitions for the dbus_uart slice.
// Holds the register offsets, STATUS bit positions and the TX/RX
// state encodings used by dbus_uart.
package dbus_uart_pkg;

    // Register offsets relative to BASE_ADDR.
    localparam logic REG_DATA   = 1'b0;
    localparam logic REG_STATUS = 1'b1;

    // STATUS register bit positions.
    localparam int ST_TX_FULL   = 0;
    localparam int ST_TX_EMPTY  = 1;
    localparam int ST_RX_VALID  = 2;
    localparam int ST_RX_OVR    = 3;
    localparam int ST_RX_FERR   = 4;
    localparam int ST_TX_BUSY   = 5;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo -- single-clock FIFO used for both the TX and RX byte queues.
// Ports:
//   i_clk, i_reset   clock, asynchronous active-high reset (empties FIFO)
//   i_push, i_din    write strobe and data; ignored when full unless popping
//   i_pop            read strobe; ignored when empty
//   o_dout           head entry (valid while o_empty=0)
//   o_full, o_empty  occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is accepted when a pop frees a slot the same cycle.
    assign do_pop  = i_pop & ~o_empty;
    assign do_push = i_push & (~o_full | do_pop);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; the pointers/count define which entries are
    // valid, so clearing the array would only cost reset fan-out.
    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr] <= i_din;
    end

    assign o_dout  = mem[rd_ptr];
    assign o_full  = (count == FULL_COUNT);
    assign o_empty = (count == '0);

endmodule

// File: rtl/dbus_uart.sv
// dbus_uart -- two-register 8N1 UART on a simple cs/ack data bus.
// Registers (word addresses):
//   BASE_ADDR+0  W: push byte to TX FIFO   R: pop RX FIFO head (0 if empty)
//   BASE_ADDR+1  R: STATUS (read clears overrun/frame error)  W: ignored
// Ports:
//   i_clk, i_reset       clock, asynchronous active-high reset
//   i_addr, i_dat, i_we  bus address, write data, write strobe
//   i_cs, o_ack          request (held until ack), one-cycle acknowledge
//   o_dat                read data, zero whenever o_ack=0
//   i_rx, o_tx           serial receive (asynchronous), serial transmit
//   o_int                interrupt, only when DBUS_UART_IRQ_EN is defined
module dbus_uart
    import dbus_uart_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = 16'hFF00,
    parameter logic [15:0] CLK_DIV    = 16'd104,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_dat,
    output logic [15:0] o_dat,
    input  logic        i_we,
    input  logic        i_cs,
    output logic        o_ack,
    input  logic        i_rx,
    output logic        o_tx
`ifdef DBUS_UART_IRQ_EN
   ,output logic        o_int
`endif
);

    localparam logic [15:0] ADDR_STATUS = BASE_ADDR + 16'd1;
    localparam logic [15:0] BIT_END     = CLK_DIV - 16'd1;
    localparam logic [15:0] HALF_END    = (CLK_DIV >> 1) - 16'd1;

    // ---------------- bus interface ----------------
    logic        reg_off, hit, acc_done;
    logic        data_wr, data_rd, status_rd;
    logic [15:0] status, rd_data;

    logic       tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0] tx_dout;
    logic       rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0] rx_dout;
    logic       rx_overrun, rx_frame_err, ovr_set, ferr_set;

    tx_state_t  tx_state, tx_state_d;
    logic [15:0] tx_cnt, tx_cnt_d;
    logic [2:0] tx_bit, tx_bit_d;
    logic [7:0] tx_shift, tx_shift_d;
    logic       tx_line_d;

    rx_state_t  rx_state, rx_state_d;
    logic [15:0] rx_cnt, rx_cnt_d;
    logic [2:0] rx_bit, rx_bit_d;
    logic [7:0] rx_shift, rx_shift_d;
    logic       rx_meta, rx_sync, rx_prev;

    // acc_done blocks a second hit while the CPU keeps i_cs asserted after
    // its ack; it clears as soon as i_cs drops between accesses.
    assign reg_off   = (i_addr == ADDR_STATUS) ? REG_STATUS : REG_DATA;
    assign hit       = i_cs & ((i_addr == BASE_ADDR) | (i_addr == ADDR_STATUS))
                       & ~o_ack & ~acc_done;
    assign data_wr   = hit & i_we  & (reg_off == REG_DATA);
    assign data_rd   = hit & ~i_we & (reg_off == REG_DATA);
    assign status_rd = hit & ~i_we & (reg_off == REG_STATUS);
    assign tx_push   = data_wr;
    assign rx_pop    = data_rd & ~rx_empty;

    always_comb begin
        status               = '0;
        status[ST_TX_FULL]   = tx_full;
        status[ST_TX_EMPTY]  = tx_empty;
        status[ST_RX_VALID]  = ~rx_empty;
        status[ST_RX_OVR]    = rx_overrun;
        status[ST_RX_FERR]   = rx_frame_err;
        status[ST_TX_BUSY]   = (tx_state != TX_IDLE);
        if (reg_off == REG_STATUS) rd_data = status;
        else                       rd_data = rx_empty ? 16'h0000 : {8'h00, rx_dout};
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_ack        <= 1'b0;
            o_dat        <= '0;
            acc_done     <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            o_ack        <= hit;
            o_dat        <= (hit & ~i_we) ? rd_data : 16'h0000;
            acc_done     <= i_cs & (acc_done | hit);
            // A new error in the clearing cycle keeps the flag set.
            rx_overrun   <= ovr_set  | (rx_overrun   & ~status_rd);
            rx_frame_err <= ferr_set | (rx_frame_err & ~status_rd);
        end
    end

`ifdef DBUS_UART_IRQ_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) o_int <= 1'b0;
        else         o_int <= ~rx_empty | rx_overrun | rx_frame_err;
    end
`endif

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .i_clk(i_clk), .i_reset(i_reset), .i_push(tx_push), .i_din(i_dat[7:0]),
        .i_pop(tx_pop), .o_dout(tx_dout), .o_full(tx_full), .o_empty(tx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .i_clk(i_clk), .i_reset(i_reset), .i_push(rx_push), .i_din(rx_shift),
        .i_pop(rx_pop), .o_dout(rx_dout), .o_full(rx_full), .o_empty(rx_empty)
    );

    // ---------------- transmitter ----------------
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        tx_state_d = tx_state;
        tx_cnt_d   = tx_cnt + 16'd1;
        tx_bit_d   = tx_bit;
        tx_shift_d = tx_shift;
        tx_pop     = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (!tx_empty) begin
                    tx_state_d = TX_START;
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_dout;
                end
            end
            TX_START: if (tx_cnt == BIT_END) begin
                tx_state_d = TX_DATA;
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
            end
            TX_DATA: if (tx_cnt == BIT_END) begin
                tx_cnt_d = '0;
                if (tx_bit == 3'd7) tx_state_d = TX_STOP;
                else begin
                    tx_bit_d   = tx_bit + 3'd1;
                    tx_shift_d = {1'b0, tx_shift[7:1]};
                end
            end
            TX_STOP: if (tx_cnt == BIT_END) begin
                tx_cnt_d = '0;
                // Queued byte starts immediately: no idle gap between frames.
                if (!tx_empty) begin
                    tx_state_d = TX_START;
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_dout;
                end else begin
                    tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        // Line level is registered from the next state so o_tx is glitch-free.
        if (tx_state_d == TX_START)     tx_line_d = 1'b0;
        else if (tx_state_d == TX_DATA) tx_line_d = tx_shift_d[0];
        else                            tx_line_d = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            o_tx     <= 1'b1;
        end else begin
            tx_state <= tx_state_d;
            tx_cnt   <= tx_cnt_d;
            tx_bit   <= tx_bit_d;
            tx_shift <= tx_shift_d;
            o_tx     <= tx_line_d;
        end
    end

    // ---------------- receiver ----------------
    always_comb begin
        rx_state_d = rx_state;
        rx_cnt_d   = rx_cnt + 16'd1;
        rx_bit_d   = rx_bit;
        rx_shift_d = rx_shift;
        rx_push    = 1'b0;
        ovr_set    = 1'b0;
        ferr_set   = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev & ~rx_sync) rx_state_d = RX_START;
            end
            RX_START: if (rx_cnt == HALF_END) begin
                rx_cnt_d = '0;
                rx_bit_d = '0;
                // High at mid start bit: treat the falling edge as a glitch.
                rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt == BIT_END) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_sync, rx_shift[7:1]};
                if (rx_bit == 3'd7) rx_state_d = RX_STOP;
                else                rx_bit_d   = rx_bit + 3'd1;
            end
            RX_STOP: if (rx_cnt == BIT_END) begin
                rx_state_d = RX_IDLE;
                if (!rx_sync)     ferr_set = 1'b1;
                else if (rx_full) ovr_set  = 1'b1;
                else              rx_push  = 1'b1;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_meta  <= i_rx;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rx_state <= rx_state_d;
            rx_cnt   <= rx_cnt_d;
            rx_bit   <= rx_bit_d;
            rx_shift <= rx_shift_d;
        end
    end

endmodule
